// File: rtl/combi_hazard_pkg.sv
// Shared types and constants for the combined ARM/RISC-V scoreboard hazard unit.
// Build option: COMBI_DUAL_ISA_EN adds a per-entry ISA bit (ARM r0 is a real register).
package combi_hazard_pkg;

  localparam int REG_MAX_W = 8;
  localparam int RDY_MAX_W = 4;

  localparam int STG_E = 1;
  localparam int STG_M = 2;

  localparam logic [RDY_MAX_W-1:0] RDY_ALU  = 4'd2;
  localparam logic [RDY_MAX_W-1:0] RDY_LOAD = 4'd3;

  typedef struct packed {
    logic                 valid;
    logic [REG_MAX_W-1:0] rd;
    logic                 regWrite;
    logic                 isaArm;
  } sb_tag_t;

  typedef struct packed {
    sb_tag_t              tag;
    logic [RDY_MAX_W-1:0] ready;
  } sb_entry_t;

  // Register 0 is hard-wired only when both producer and consumer are RISC-V.
  function automatic logic sbMatch(sb_tag_t e, logic [REG_MAX_W-1:0] r, logic consumerArm);
    logic zeroReg;
    zeroReg = (r == '0) && !consumerArm && !e.isaArm;
    return e.valid && e.regWrite && (e.rd == r) && !zeroReg;
  endfunction

endpackage

// File: rtl/combi_fwd_sel.sv
// Forward-source priority select for one execute operand: youngest matching
// producer in stages M..W wins, 0 selects the register file.
module combi_fwd_sel
  import combi_hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int SEL_W = 2
) (
  input  sb_tag_t [DEPTH:2]       tags,
  input  logic [REG_MAX_W-1:0]    rs,
  input  logic                    srcUse,
  input  logic                    consumerArm,
  output logic [SEL_W-1:0]        sel
);

  always_comb begin
    sel = '0;
    for (int s = DEPTH; s >= STG_M; s--) begin
      if (srcUse && sbMatch(tags[s], rs, consumerArm)) sel = SEL_W'(s);
    end
  end

endmodule

// File: rtl/combi_hazard_sb.sv
// Scoreboard hazard unit: stalls, flushes and forward selects for a DEPTH-stage back end.
// Build option: COMBI_DUAL_ISA_EN adds the IsaArmD port and ARM r0 tracking.
module combi_hazard_sb
  import combi_hazard_pkg::*;
#(
  parameter int  DEPTH = 3,
  parameter int  REG_W = 5,
  localparam int RDY_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic             Use1D,
  input  logic             Use2D,
  input  logic [REG_W-1:0] RdD,
  input  logic             RegWriteD,
  input  logic [RDY_W-1:0] ReadyD,
  input  logic             RedirectE,
`ifdef COMBI_DUAL_ISA_EN
  input  logic             IsaArmD,
`endif
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic [RDY_W-1:0] ForwardAE,
  output logic [RDY_W-1:0] ForwardBE
);

  sb_entry_t [DEPTH:1]  entries;
  sb_tag_t   [DEPTH:2]  fwdTags;
  sb_entry_t            newEntry;
  logic                 dvalid;
  logic [REG_MAX_W-1:0] rs1E, rs2E;
  logic                 use1E, use2E, armE, armD;
  logic [RDY_MAX_W-1:0] readyEff;
  logic                 ldStall;
  logic [RDY_W-1:0]     fwdA, fwdB;

`ifdef COMBI_DUAL_ISA_EN
  assign armD = IsaArmD;
`else
  assign armD = 1'b0;
`endif

  // An E-stage result is never visible before M.
  assign readyEff = (ReadyD < RDY_W'(STG_M)) ? RDY_ALU : RDY_MAX_W'(ReadyD);

  // The last stage can never hold a not-yet-ready producer, so scanning it is harmless.
  always_comb begin
    ldStall = 1'b0;
    for (int s = 1; s <= DEPTH; s++) begin
      if (int'(entries[s].ready) > s + 1 &&
          ((Use1D && sbMatch(entries[s].tag, REG_MAX_W'(Rs1D), armD)) ||
           (Use2D && sbMatch(entries[s].tag, REG_MAX_W'(Rs2D), armD))))
        ldStall = 1'b1;
    end
    ldStall = ldStall & dvalid;
  end

  always_comb begin
    if (!rst) begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      ForwardAE = '0;
      ForwardBE = '0;
    end else begin
      StallF    = ldStall & ~RedirectE;
      StallD    = ldStall & ~RedirectE;
      FlushD    = RedirectE;
      FlushE    = ldStall | RedirectE;
      ForwardAE = fwdA;
      ForwardBE = fwdB;
    end
  end

  always_comb begin
    newEntry              = '0;
    newEntry.tag.valid    = dvalid & ~FlushE;
    newEntry.tag.rd       = REG_MAX_W'(RdD);
    newEntry.tag.regWrite = RegWriteD;
    newEntry.tag.isaArm   = armD;
    newEntry.ready        = readyEff;
  end

  // D/E boundary and post-decode shift: payload is unreset, only valid/use bits clear.
  always_ff @(posedge clk) begin
    for (int k = DEPTH; k >= 2; k--) entries[k] <= entries[k-1];
    entries[1] <= newEntry;
    rs1E       <= REG_MAX_W'(Rs1D);
    rs2E       <= REG_MAX_W'(Rs2D);
    armE       <= armD;
    if (!rst) begin
      for (int k = 1; k <= DEPTH; k++) entries[k].tag.valid <= 1'b0;
      use1E  <= 1'b0;
      use2E  <= 1'b0;
      dvalid <= 1'b0;
    end else begin
      use1E  <= newEntry.tag.valid & Use1D;
      use2E  <= newEntry.tag.valid & Use2D;
      dvalid <= FlushD ? 1'b0 : (StallD ? dvalid : 1'b1);
    end
  end

  always_comb begin
    fwdTags = '0;
    for (int s = 2; s <= DEPTH; s++) fwdTags[s] = entries[s].tag;
  end

  combi_fwd_sel #(.DEPTH(DEPTH), .SEL_W(RDY_W)) uFwdA (
    .tags        (fwdTags),
    .rs          (rs1E),
    .srcUse      (use1E),
    .consumerArm (armE),
    .sel         (fwdA)
  );

  combi_fwd_sel #(.DEPTH(DEPTH), .SEL_W(RDY_W)) uFwdB (
    .tags        (fwdTags),
    .rs          (rs2E),
    .srcUse      (use2E),
    .consumerArm (armE),
    .sel         (fwdB)
  );

endmodule

// File: tb/tb_combi_hazard_sb.sv
// Bench for combi_hazard_sb at DEPTH=3 and DEPTH=5 sharing one decode stream.
// Build option: COMBI_DUAL_ISA_EN enables the ARM r0 scenario and random ISA bits.
module tb_combi_hazard_sb;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic       Use1D, Use2D, RegWriteD, RedirectE, IsaArmD;
  logic [1:0] ReadyD3;
  logic [2:0] ReadyD5;
  logic       StallF3, StallD3, FlushD3, FlushE3;
  logic [1:0] FwdA3, FwdB3;
  logic       StallF5, StallD5, FlushD5, FlushE5;
  logic [2:0] FwdA5, FwdB5;

  always #5 clk = ~clk;

  combi_hazard_sb #(.DEPTH(3), .REG_W(5)) dut3 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Use1D(Use1D), .Use2D(Use2D),
    .RdD(RdD), .RegWriteD(RegWriteD), .ReadyD(ReadyD3), .RedirectE(RedirectE),
`ifdef COMBI_DUAL_ISA_EN
    .IsaArmD(IsaArmD),
`endif
    .StallF(StallF3), .StallD(StallD3), .FlushD(FlushD3), .FlushE(FlushE3),
    .ForwardAE(FwdA3), .ForwardBE(FwdB3)
  );

  combi_hazard_sb #(.DEPTH(5), .REG_W(5)) dut5 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Use1D(Use1D), .Use2D(Use2D),
    .RdD(RdD), .RegWriteD(RegWriteD), .ReadyD(ReadyD5), .RedirectE(RedirectE),
`ifdef COMBI_DUAL_ISA_EN
    .IsaArmD(IsaArmD),
`endif
    .StallF(StallF5), .StallD(StallD5), .FlushD(FlushD5), .FlushE(FlushE5),
    .ForwardAE(FwdA5), .ForwardBE(FwdB5)
  );

  // Reference model: instructions remembered by the cycle they entered E.
  typedef struct { bit v; int rd; bit wr; int rdy; bit arm; } rec_t;
  typedef struct { int rs1; int rs2; bit u1; bit u2; bit arm; } cons_t;

  rec_t  hist [2][16];
  cons_t eCons [2];
  bit    dHas [2];
  bit    expStall [2], expFlushD [2], expFlushE [2];
  int    depthOf [2] = '{3, 5};
  int    cyc = 0;
  int    checks = 0, errors = 0;

  task automatic checkEq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic bit writesAt(int i, int s, int r, bit arm);
    rec_t p;
    p = hist[i][(cyc - s + 1) & 15];
    return p.v && p.wr && (p.rd == r) && !(r == 0 && !arm && !p.arm);
  endfunction

  function automatic int youngest(int i, int r, bit u, bit arm);
    if (!u) return 0;
    for (int s = 2; s <= depthOf[i]; s++) if (writesAt(i, s, r, arm)) return s;
    return 0;
  endfunction

  function automatic bit notReady(int i, int r, bit u, bit arm);
    if (!u) return 0;
    for (int s = 1; s < depthOf[i]; s++)
      if (writesAt(i, s, r, arm) && hist[i][(cyc - s + 1) & 15].rdy > s + 1) return 1;
    return 0;
  endfunction

  task automatic probe();
    int sf, sd, fd, fe, fa, fb, eSf, eFd, eFe, eFa, eFb;
    bit stall;
    string d;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      d = $sformatf("_d%0d", depthOf[i]);
      if (i == 0) begin
        sf = StallF3; sd = StallD3; fd = FlushD3; fe = FlushE3; fa = FwdA3; fb = FwdB3;
      end else begin
        sf = StallF5; sd = StallD5; fd = FlushD5; fe = FlushE5; fa = FwdA5; fb = FwdB5;
      end
      stall = dHas[i] && (notReady(i, Rs1D, Use1D, IsaArmD) || notReady(i, Rs2D, Use2D, IsaArmD));
      if (!rst) begin
        eSf = 0; eFd = 1; eFe = 1; eFa = 0; eFb = 0;
      end else begin
        eSf = stall && !RedirectE;
        eFd = RedirectE;
        eFe = stall || RedirectE;
        eFa = youngest(i, eCons[i].rs1, eCons[i].u1, eCons[i].arm);
        eFb = youngest(i, eCons[i].rs2, eCons[i].u2, eCons[i].arm);
      end
      expStall[i] = eSf[0]; expFlushD[i] = eFd[0]; expFlushE[i] = eFe[0];
      checkEq({"StallF", d}, sf, eSf);
      checkEq({"StallD", d}, sd, eSf);
      checkEq({"FlushD", d}, fd, eFd);
      checkEq({"FlushE", d}, fe, eFe);
      checkEq({"ForwardAE", d}, fa, eFa);
      checkEq({"ForwardBE", d}, fb, eFb);
      if (rst && fa != 0) begin
        rec_t p;
        p = hist[i][(cyc - fa + 1) & 15];
        checkEq({"fwdReadyA", d}, int'(p.v && p.rdy <= fa), 1);
      end
    end
  endtask

  task automatic tick();
    int rdy;
    bit enter;
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        for (int k = 0; k < 16; k++) hist[i][k].v = 0;
        eCons[i].u1 = 0; eCons[i].u2 = 0;
        dHas[i] = 0;
      end else begin
        rdy   = (i == 0) ? int'(ReadyD3) : int'(ReadyD5);
        if (rdy < 2) rdy = 2;
        enter = dHas[i] && !expFlushE[i];
        hist[i][(cyc + 1) & 15] = '{enter, int'(RdD), RegWriteD, rdy, IsaArmD};
        eCons[i] = '{int'(Rs1D), int'(Rs2D), enter && Use1D, enter && Use2D, IsaArmD};
        dHas[i]  = expFlushD[i] ? 1'b0 : (expStall[i] ? dHas[i] : 1'b1);
      end
    end
    cyc++;
    #1;
  endtask

  task automatic setD(input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit wr, input int rdy, input bit arm);
    Rs1D = 5'(rs1); Use1D = u1; Rs2D = 5'(rs2); Use2D = u2;
    RdD = 5'(rd); RegWriteD = wr; IsaArmD = arm;
    ReadyD5 = 3'(rdy);
    ReadyD3 = 2'((rdy > 3) ? 3 : rdy);
  endtask

  task automatic nop();
    setD(0, 0, 0, 0, 0, 0, 2, 0);
  endtask

  // Two reset cycles, then one bubble cycle so decode holds a real instruction.
  task automatic restart();
    rst = 1'b0; RedirectE = 1'b0; nop();
    probe(); tick(); probe(); tick();
    rst = 1'b1;
    probe(); tick();
  endtask

  initial begin
    restart();

    // ALU producer then two readers: M forward, then W forward.
    setD(0, 0, 0, 0, 5, 1, 2, 0); probe(); tick();
    setD(5, 1, 0, 0, 8, 1, 2, 0); probe(); checkEq("aluNoStall", StallF3, 0); tick();
    setD(5, 1, 0, 0, 9, 1, 2, 0); probe(); checkEq("fwdFromM", FwdA3, 2); tick();
    nop();                         probe(); checkEq("fwdFromW", FwdA3, 3); tick();

    // Load-use: one bubble, then forward from W.
    restart();
    setD(0, 0, 0, 0, 6, 1, 3, 0);  probe(); tick();
    setD(6, 1, 0, 0, 10, 1, 2, 0); probe();
    checkEq("luStallF", StallF3, 1); checkEq("luStallD", StallD3, 1); checkEq("luFlushE", FlushE3, 1);
    tick();
    probe(); checkEq("luRelease", StallF3, 0); tick();
    nop(); probe(); checkEq("luFwdW", FwdA3, 3); tick();

    // Two writers of x7: youngest (M) wins over W.
    restart();
    setD(0, 0, 0, 0, 7, 1, 2, 0); probe(); tick();
    setD(0, 0, 0, 0, 7, 1, 2, 0); probe(); tick();
    setD(7, 1, 7, 1, 12, 1, 2, 0); probe(); tick();
    nop(); probe(); checkEq("youngestA", FwdA3, 2); checkEq("youngestB", FwdB3, 2); tick();

    // Redirect during a load-use stall: redirect wins.
    restart();
    setD(0, 0, 0, 0, 6, 1, 3, 0); probe(); tick();
    setD(6, 1, 0, 0, 10, 1, 2, 0); RedirectE = 1'b1; probe();
    checkEq("redirStallF", StallF3, 0); checkEq("redirFlushD", FlushD3, 1); checkEq("redirFlushE", FlushE3, 1);
    tick();
    RedirectE = 1'b0; probe(); checkEq("wrongPathStall", StallF3, 0); checkEq("wrongPathFlushE", FlushE3, 0); tick();
    nop(); probe(); checkEq("bubbleNoFwd", FwdA3, 0); tick();

    // RISC-V x0 never creates a dependency.
    restart();
    setD(0, 0, 0, 0, 0, 1, 3, 0); probe(); tick();
    setD(0, 1, 0, 1, 4, 1, 2, 0); probe(); checkEq("x0NoStall", StallF3, 0); tick();
    nop(); probe(); checkEq("x0NoFwdA", FwdA3, 0); checkEq("x0NoFwdB", FwdB3, 0); tick();
`ifdef COMBI_DUAL_ISA_EN
    restart();
    setD(0, 0, 0, 0, 0, 1, 2, 1); probe(); tick();
    setD(0, 1, 0, 0, 4, 1, 2, 1); probe(); tick();
    nop(); probe(); checkEq("armR0Fwd", FwdA3, 2); tick();
`endif

    // DEPTH=5, ready at stage 4: two bubbles, then forward from stage 4.
    restart();
    setD(0, 0, 0, 0, 11, 1, 4, 0);  probe(); tick();
    setD(11, 1, 0, 0, 13, 1, 2, 0); probe(); checkEq("deepStall1", StallF5, 1); tick();
    probe(); checkEq("deepStall2", StallF5, 1); tick();
    probe(); checkEq("deepRelease", StallF5, 0); tick();
    nop(); probe(); checkEq("deepFwd4", FwdA5, 4); tick();

    // Reset in the middle of a stall empties the scoreboard.
    restart();
    setD(0, 0, 0, 0, 11, 1, 4, 0);  probe(); tick();
    setD(11, 1, 0, 0, 13, 1, 2, 0); probe(); checkEq("preRstStall", StallF5, 1); tick();
    rst = 1'b0; probe();
    checkEq("rstStallF", StallF5, 0); checkEq("rstFlushD", FlushD5, 1); checkEq("rstFlushE", FlushE5, 1);
    tick();
    rst = 1'b1; probe(); checkEq("postRstStall0", StallF5, 0); tick();
    probe(); checkEq("postRstStall1", StallF5, 0); tick();
    nop(); probe(); checkEq("postRstNoFwd", FwdA5, 0); tick();

    // Random traffic over a small register set to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      bit arm;
`ifdef COMBI_DUAL_ISA_EN
      arm = 1'($urandom_range(0, 1));
`else
      arm = 1'b0;
`endif
      rst = ($urandom_range(0, 39) != 0);
      RedirectE = ($urandom_range(0, 7) == 0);
      setD($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           $urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom_range(1, 5), arm);
      probe(); tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
